// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder: handshake states, register
// offsets, STATUS bit layout and the byte-enable merge helper.
package mmio_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam logic [7:0] OFF_OUT      = 8'h00;
  localparam logic [7:0] OFF_CYCLE_LO = 8'h04;
  localparam logic [7:0] OFF_CYCLE_HI = 8'h08;
  localparam logic [7:0] OFF_TIMECMP  = 8'h0C;
  localparam logic [7:0] OFF_STATUS   = 8'h10;
  localparam logic [7:0] OFF_SCRATCH  = 8'h14;

  localparam int STATUS_PENDING_BIT = 0;

  // Replace each byte lane of old_v whose enable is set with the lane from new_v.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[b*8 +: 8] = new_v[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_v[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Free-running 64-bit cycle counter with a HI-word shadow that is captured
// whenever the LO word is read, so software sees a coherent 64-bit value.
module cycle_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snapshot,
  output logic [63:0] cycle,
  output logic [31:0] hi_shadow
);

  logic [63:0] cycle_r;
  logic [31:0] hi_r;

  // Count every cycle; capture the pre-edge HI word on a snapshot request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_r <= 64'd0;
      hi_r    <= 32'd0;
    end else begin
      cycle_r <= cycle_r + 64'd1;
      if (snapshot) begin
        hi_r <= cycle_r[63:32];
      end else begin
        hi_r <= hi_r;
      end
    end
  end

  assign cycle     = cycle_r;
  assign hi_shadow = hi_r;

endmodule

// File: rtl/mmio_responder.sv
// LSU-facing MMIO target: address decode, request/response handshake and the
// register file (board output, timer compare/status, scratch).
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          OUT_W       = 9,
  parameter logic [31:0] TIMECMP_RST = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [OUT_W-1:0]  out_port,
  output logic              timer_irq
);

  state_e            state_r;
  logic [OUT_W-1:0]  out_r;
  logic [31:0]       timecmp_r;
  logic [31:0]       scratch_r;
  logic              pending_r;
  logic              rsp_valid_r;
  logic              rsp_err_r;
  logic [31:0]       rsp_rdata_r;

  logic [63:0]       cycle_s;
  logic [31:0]       hi_shadow_s;
  logic              req_ready_s;
  logic              accept_s;
  logic              sel_out_s, sel_cyclo_s, sel_cychi_s;
  logic              sel_timecmp_s, sel_status_s, sel_scratch_s;
  logic              err_s;
  logic              wr_ok_s;
  logic              snapshot_s;
  logic              clear_s;
  logic              match_s;
  logic [31:0]       rdata_s;
  logic [OUT_W-1:0]  out_next_s;

  // The responder is ready in IDLE, or in RESP when the current response drains.
  always_comb begin
    req_ready_s = 1'b0;
    case (state_r)
      IDLE:    req_ready_s = rst_n;
      RESP:    req_ready_s = rst_n & rsp_ready;
      default: req_ready_s = 1'b0;
    endcase
  end

  // Full-address decode; any upper address bit set is unmapped.
  always_comb begin
    sel_out_s     = (req_addr == ADDR_W'(OFF_OUT));
    sel_cyclo_s   = (req_addr == ADDR_W'(OFF_CYCLE_LO));
    sel_cychi_s   = (req_addr == ADDR_W'(OFF_CYCLE_HI));
    sel_timecmp_s = (req_addr == ADDR_W'(OFF_TIMECMP));
    sel_status_s  = (req_addr == ADDR_W'(OFF_STATUS));
    sel_scratch_s = (req_addr == ADDR_W'(OFF_SCRATCH));
    err_s = (req_addr[1:0] != 2'b00) |
            ~(sel_out_s | sel_cyclo_s | sel_cychi_s |
              sel_timecmp_s | sel_status_s | sel_scratch_s);
    accept_s   = req_valid & req_ready_s;
    wr_ok_s    = accept_s & req_we & ~err_s;
    snapshot_s = accept_s & ~req_we & ~err_s & sel_cyclo_s;
    clear_s    = wr_ok_s & sel_status_s & req_be[0] & req_wdata[STATUS_PENDING_BIT];
    match_s    = (cycle_s[31:0] == timecmp_r);
    out_next_s = OUT_W'(be_merge(32'(out_r), req_wdata, req_be));
  end

  // Load data from pre-edge register values; stores and errors return zero.
  always_comb begin
    rdata_s = 32'd0;
    if (err_s || req_we) begin
      rdata_s = 32'd0;
    end else if (sel_out_s) begin
      rdata_s = 32'(out_r);
    end else if (sel_cyclo_s) begin
      rdata_s = cycle_s[31:0];
    end else if (sel_cychi_s) begin
      rdata_s = hi_shadow_s;
    end else if (sel_timecmp_s) begin
      rdata_s = timecmp_r;
    end else if (sel_status_s) begin
      rdata_s = 32'(pending_r) << STATUS_PENDING_BIT;
    end else if (sel_scratch_s) begin
      rdata_s = scratch_r;
    end else begin
      rdata_s = 32'd0;
    end
  end

  cycle_counter u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .snapshot  (snapshot_s),
    .cycle     (cycle_s),
    .hi_shadow (hi_shadow_s)
  );

  // Handshake FSM and registered response; a stalled response holds its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else if (accept_s) begin
      state_r     <= RESP;
      rsp_valid_r <= 1'b1;
      rsp_rdata_r <= rdata_s;
      rsp_err_r   <= err_s;
    end else if ((state_r == RESP) && rsp_ready) begin
      state_r     <= IDLE;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_r;
      rsp_valid_r <= rsp_valid_r;
      rsp_rdata_r <= rsp_rdata_r;
      rsp_err_r   <= rsp_err_r;
    end
  end

  // Register file writes; a timer match outranks a simultaneous W1C clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r     <= '0;
      timecmp_r <= TIMECMP_RST;
      scratch_r <= 32'd0;
      pending_r <= 1'b0;
    end else begin
      if (wr_ok_s && sel_out_s) begin
        out_r <= out_next_s;
      end else begin
        out_r <= out_r;
      end
      if (wr_ok_s && sel_timecmp_s) begin
        timecmp_r <= be_merge(timecmp_r, req_wdata, req_be);
      end else begin
        timecmp_r <= timecmp_r;
      end
      if (wr_ok_s && sel_scratch_s) begin
        scratch_r <= be_merge(scratch_r, req_wdata, req_be);
      end else begin
        scratch_r <= scratch_r;
      end
      if (match_s) begin
        pending_r <= 1'b1;
      end else if (clear_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign out_port  = out_r;
  assign timer_irq = pending_r;

endmodule
